// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
//   Circular reorder buffer for an out-of-order core. Instructions are
//   allocated in program order at the tail, completed out of order by the
//   common data bus (CDB), and retired in order from the head, one per cycle.
//   A retiring branch whose actual direction differs from its prediction
//   flushes the whole buffer and requests a pipeline rollback.
//
// Parameters
//   ROB_CAPACITY : number of entries (max 15). Slot i carries tag i+1, tag 0
//                  is the null tag.
//
// Configuration macro
//   ROB_CDB_BYPASS_EN : when defined, operand queries see a CDB broadcast for
//                       a busy tag in the same cycle. When undefined, queries
//                       reflect stored state only.
//
// Ports
//   clk, rst                : clock, asynchronous active-low reset
//   dec_*_in                : allocation request and operand-tag queries
//   next_tag_out            : tag the next issue receives
//   rob_full_out            : no free entry
//   Qj/Qk_ready/value_out   : result availability for the queried tags
//   cdb_*_in                : result broadcast (tag, value, branch outcome)
//   rob_commit_*_out        : registered one-cycle commit pulse and payload
//   rob_rollback_*_out      : registered flush request and restart pc
// ---------------------------------------------------------------------------
module reorder_buffer #(
    parameter int ROB_CAPACITY = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_issue_in,
    input  logic [31:0] dec_pc_in,
    input  logic [4:0]  dec_rd_in,
    input  logic        dec_has_rd_in,
    input  logic        dec_is_store_in,
    input  logic        dec_is_branch_in,
    input  logic        dec_pred_taken_in,
    input  logic [3:0]  dec_Qj_in,
    input  logic [3:0]  dec_Qk_in,
    output logic [3:0]  next_tag_out,
    output logic        rob_full_out,
    output logic        Qj_ready_out,
    output logic        Qk_ready_out,
    output logic [31:0] Qj_value_out,
    output logic [31:0] Qk_value_out,
    input  logic        cdb_valid_in,
    input  logic [3:0]  cdb_tag_in,
    input  logic [31:0] cdb_value_in,
    input  logic        cdb_taken_in,
    input  logic [31:0] cdb_target_in,
    output logic        rob_commit_signal_out,
    output logic        rob_commit_rf_signal_out,
    output logic [31:0] rob_commit_pc_out,
    output logic [3:0]  rob_commit_tag_out,
    output logic [31:0] rob_commit_data_out,
    output logic [4:0]  rob_commit_target_out,
    output logic        rob_commit_store_out,
    output logic        rob_rollback_out,
    output logic [31:0] rob_rollback_pc_out
);

    localparam logic [3:0] CAP_W    = 4'(ROB_CAPACITY);
    localparam logic [3:0] LAST_IDX = 4'(ROB_CAPACITY - 1);

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        has_rd;
        logic        is_store;
        logic        is_branch;
        logic        pred_taken;
        logic [31:0] value;
        logic        taken;
        logic [31:0] target;
    } entry_t;

    function automatic logic [3:0] wrap_inc(input logic [3:0] idx);
        if (idx == LAST_IDX) begin
            return 4'd0;
        end else begin
            return idx + 4'd1;
        end
    endfunction

    function automatic logic tag_in_range(input logic [3:0] tag);
        return (tag != 4'd0) && (tag <= CAP_W);
    endfunction

    // Stored-state lookup: {ready, value}; unknown or idle tags read as zero.
    function automatic logic [32:0] stored_lookup(input logic [3:0] tag, input entry_t e);
        if (tag_in_range(tag) && e.busy) begin
            return {e.ready, e.value};
        end else begin
            return {1'b0, 32'd0};
        end
    endfunction

    entry_t      ent_q [ROB_CAPACITY];
    entry_t      ent_d [ROB_CAPACITY];
    logic [3:0]  head_q, head_d, tail_q, tail_d, count_q, count_d;

    logic        commit_sig_q, commit_sig_d, commit_rf_q, commit_rf_d;
    logic [31:0] commit_pc_q, commit_pc_d, commit_data_q, commit_data_d;
    logic [3:0]  commit_tag_q, commit_tag_d;
    logic [4:0]  commit_target_q, commit_target_d;
    logic        commit_store_q, commit_store_d, rollback_q, rollback_d;
    logic [31:0] rollback_pc_q, rollback_pc_d;

    logic        full_s, commit_s, mispredict_s, issue_ok_s, cdb_hit_s;
    logic [3:0]  cdb_idx_s, qj_idx_s, qk_idx_s;
    entry_t      head_ent_s;

    assign full_s       = (count_q == CAP_W);
    assign head_ent_s   = ent_q[head_q];
    assign commit_s     = head_ent_s.busy && head_ent_s.ready;
    assign mispredict_s = commit_s && head_ent_s.is_branch &&
                          (head_ent_s.taken != head_ent_s.pred_taken);
    // A committing entry frees a slot, so a full buffer can still accept.
    assign issue_ok_s   = dec_issue_in && (!full_s || commit_s);
    assign cdb_idx_s    = tag_in_range(cdb_tag_in) ? (cdb_tag_in - 4'd1) : 4'd0;
    assign cdb_hit_s    = cdb_valid_in && tag_in_range(cdb_tag_in) && ent_q[cdb_idx_s].busy;
    assign qj_idx_s     = tag_in_range(dec_Qj_in) ? (dec_Qj_in - 4'd1) : 4'd0;
    assign qk_idx_s     = tag_in_range(dec_Qk_in) ? (dec_Qk_in - 4'd1) : 4'd0;

    assign next_tag_out = tail_q + 4'd1;
    assign rob_full_out = full_s;

    // Operand queries, optionally forwarding a same-cycle CDB broadcast.
    always_comb begin
        {Qj_ready_out, Qj_value_out} = stored_lookup(dec_Qj_in, ent_q[qj_idx_s]);
        {Qk_ready_out, Qk_value_out} = stored_lookup(dec_Qk_in, ent_q[qk_idx_s]);
`ifdef ROB_CDB_BYPASS_EN
        if (cdb_valid_in && tag_in_range(dec_Qj_in) && (cdb_tag_in == dec_Qj_in) && ent_q[qj_idx_s].busy) begin
            Qj_ready_out = 1'b1;
            Qj_value_out = cdb_value_in;
        end else begin
            Qj_ready_out = Qj_ready_out;
        end
        if (cdb_valid_in && tag_in_range(dec_Qk_in) && (cdb_tag_in == dec_Qk_in) && ent_q[qk_idx_s].busy) begin
            Qk_ready_out = 1'b1;
            Qk_value_out = cdb_value_in;
        end else begin
            Qk_ready_out = Qk_ready_out;
        end
`endif
    end

    // Next-state: CDB write, commit, issue, and mispredict flush.
    always_comb begin
        ent_d           = ent_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        commit_sig_d    = 1'b0;
        commit_rf_d     = 1'b0;
        commit_pc_d     = 32'd0;
        commit_tag_d    = 4'd0;
        commit_data_d   = 32'd0;
        commit_target_d = 5'd0;
        commit_store_d  = 1'b0;
        rollback_d      = 1'b0;
        rollback_pc_d   = 32'd0;

        if (commit_s) begin
            commit_sig_d    = 1'b1;
            commit_rf_d     = head_ent_s.has_rd && (head_ent_s.rd != 5'd0);
            commit_pc_d     = head_ent_s.pc;
            commit_tag_d    = head_q + 4'd1;
            commit_data_d   = head_ent_s.value;
            commit_target_d = head_ent_s.rd;
            commit_store_d  = head_ent_s.is_store;
        end else begin
            commit_sig_d    = 1'b0;
        end

        if (mispredict_s) begin
            // Flush: same-cycle issue and CDB writes are dropped.
            rollback_d    = 1'b1;
            rollback_pc_d = head_ent_s.target;
            for (int i = 0; i < ROB_CAPACITY; i++) begin
                ent_d[i].busy  = 1'b0;
                ent_d[i].ready = 1'b0;
            end
            head_d  = 4'd0;
            tail_d  = 4'd0;
            count_d = 4'd0;
        end else begin
            if (cdb_hit_s) begin
                ent_d[cdb_idx_s].ready  = 1'b1;
                ent_d[cdb_idx_s].value  = cdb_value_in;
                ent_d[cdb_idx_s].taken  = cdb_taken_in;
                ent_d[cdb_idx_s].target = cdb_target_in;
            end else begin
                ent_d[cdb_idx_s].ready  = ent_q[cdb_idx_s].ready;
            end
            if (commit_s) begin
                ent_d[head_q].busy  = 1'b0;
                ent_d[head_q].ready = 1'b0;
                head_d = wrap_inc(head_q);
            end else begin
                head_d = head_q;
            end
            // Issue is applied last so a reused head slot gets the new entry.
            if (issue_ok_s) begin
                ent_d[tail_q] = '{busy: 1'b1, ready: 1'b0, pc: dec_pc_in, rd: dec_rd_in,
                                  has_rd: dec_has_rd_in, is_store: dec_is_store_in,
                                  is_branch: dec_is_branch_in, pred_taken: dec_pred_taken_in,
                                  value: 32'd0, taken: 1'b0, target: 32'd0};
                tail_d = wrap_inc(tail_q);
            end else begin
                tail_d = tail_q;
            end
            case ({issue_ok_s, commit_s})
                2'b10:   count_d = count_q + 4'd1;
                2'b01:   count_d = count_q - 4'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // State and registered commit/rollback outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ROB_CAPACITY; i++) begin
                ent_q[i] <= '0;
            end
            head_q          <= 4'd0;
            tail_q          <= 4'd0;
            count_q         <= 4'd0;
            commit_sig_q    <= 1'b0;
            commit_rf_q     <= 1'b0;
            commit_pc_q     <= 32'd0;
            commit_tag_q    <= 4'd0;
            commit_data_q   <= 32'd0;
            commit_target_q <= 5'd0;
            commit_store_q  <= 1'b0;
            rollback_q      <= 1'b0;
            rollback_pc_q   <= 32'd0;
        end else begin
            ent_q           <= ent_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            commit_sig_q    <= commit_sig_d;
            commit_rf_q     <= commit_rf_d;
            commit_pc_q     <= commit_pc_d;
            commit_tag_q    <= commit_tag_d;
            commit_data_q   <= commit_data_d;
            commit_target_q <= commit_target_d;
            commit_store_q  <= commit_store_d;
            rollback_q      <= rollback_d;
            rollback_pc_q   <= rollback_pc_d;
        end
    end

    assign rob_commit_signal_out    = commit_sig_q;
    assign rob_commit_rf_signal_out = commit_rf_q;
    assign rob_commit_pc_out        = commit_pc_q;
    assign rob_commit_tag_out       = commit_tag_q;
    assign rob_commit_data_out      = commit_data_q;
    assign rob_commit_target_out    = commit_target_q;
    assign rob_commit_store_out     = commit_store_q;
    assign rob_rollback_out         = rollback_q;
    assign rob_rollback_pc_out      = rollback_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer
//   Directed scenarios followed by randomized traffic. A behavioural model
//   (in-order tag queue plus per-tag records) predicts each commit; the
//   expected commit is queued at the clock edge and a separate monitor pops
//   and compares it against the registered commit outputs.
// ---------------------------------------------------------------------------
module tb_reorder_buffer;
    localparam int CAP = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_issue_in, dec_has_rd_in, dec_is_store_in, dec_is_branch_in, dec_pred_taken_in;
    logic [31:0] dec_pc_in;
    logic [4:0]  dec_rd_in;
    logic [3:0]  dec_Qj_in, dec_Qk_in;
    logic [3:0]  next_tag_out;
    logic        rob_full_out, Qj_ready_out, Qk_ready_out;
    logic [31:0] Qj_value_out, Qk_value_out;
    logic        cdb_valid_in, cdb_taken_in;
    logic [3:0]  cdb_tag_in;
    logic [31:0] cdb_value_in, cdb_target_in;
    logic        rob_commit_signal_out, rob_commit_rf_signal_out, rob_commit_store_out, rob_rollback_out;
    logic [31:0] rob_commit_pc_out, rob_commit_data_out, rob_rollback_pc_out;
    logic [3:0]  rob_commit_tag_out;
    logic [4:0]  rob_commit_target_out;

    always #5 clk = ~clk;

    reorder_buffer #(.ROB_CAPACITY(CAP)) dut (
        .clk(clk), .rst(rst),
        .dec_issue_in(dec_issue_in), .dec_pc_in(dec_pc_in), .dec_rd_in(dec_rd_in),
        .dec_has_rd_in(dec_has_rd_in), .dec_is_store_in(dec_is_store_in),
        .dec_is_branch_in(dec_is_branch_in), .dec_pred_taken_in(dec_pred_taken_in),
        .dec_Qj_in(dec_Qj_in), .dec_Qk_in(dec_Qk_in),
        .next_tag_out(next_tag_out), .rob_full_out(rob_full_out),
        .Qj_ready_out(Qj_ready_out), .Qk_ready_out(Qk_ready_out),
        .Qj_value_out(Qj_value_out), .Qk_value_out(Qk_value_out),
        .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_value_in(cdb_value_in),
        .cdb_taken_in(cdb_taken_in), .cdb_target_in(cdb_target_in),
        .rob_commit_signal_out(rob_commit_signal_out),
        .rob_commit_rf_signal_out(rob_commit_rf_signal_out),
        .rob_commit_pc_out(rob_commit_pc_out), .rob_commit_tag_out(rob_commit_tag_out),
        .rob_commit_data_out(rob_commit_data_out), .rob_commit_target_out(rob_commit_target_out),
        .rob_commit_store_out(rob_commit_store_out),
        .rob_rollback_out(rob_rollback_out), .rob_rollback_pc_out(rob_rollback_pc_out)
    );

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  tag;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rf;
        logic        st;
        logic        rb;
        logic [31:0] rbpc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: in-flight tags in program order plus per-tag records.
    int          rob_q[$];
    int          m_next;
    logic        m_busy [16];
    logic        m_ready[16];
    logic        m_has_rd[16], m_st[16], m_br[16], m_pred[16], m_taken[16];
    logic [31:0] m_pc[16], m_val[16], m_tgt[16];
    logic [4:0]  m_rd[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        rob_q.delete();
        for (int i = 0; i < 16; i++) begin
            m_busy[i]  = 1'b0;
            m_ready[i] = 1'b0;
        end
        m_next = 1;
    endfunction

    task automatic model_step();
        int   sz;
        int   h;
        int   t;
        bit   commit;
        bit   misp;
        exp_t e;
        sz     = rob_q.size();
        commit = (sz > 0) && m_ready[rob_q[0]];
        misp   = 1'b0;
        h      = 0;
        if (commit) begin
            h      = rob_q[0];
            e.pc   = m_pc[h];
            e.tag  = 4'(h);
            e.data = m_val[h];
            e.rd   = m_rd[h];
            e.rf   = m_has_rd[h] && (m_rd[h] != 5'd0);
            e.st   = m_st[h];
            misp   = m_br[h] && (m_taken[h] != m_pred[h]);
            e.rb   = misp;
            e.rbpc = misp ? m_tgt[h] : 32'd0;
            exp_q.push_back(e);
        end
        if (misp) begin
            model_reset();
            return;
        end
        if (cdb_valid_in && cdb_tag_in != 4'd0 && m_busy[cdb_tag_in]) begin
            m_ready[cdb_tag_in] = 1'b1;
            m_val[cdb_tag_in]   = cdb_value_in;
            m_taken[cdb_tag_in] = cdb_taken_in;
            m_tgt[cdb_tag_in]   = cdb_target_in;
        end
        if (commit) begin
            m_busy[h] = 1'b0;
            void'(rob_q.pop_front());
        end
        if (dec_issue_in && (sz < CAP || commit)) begin
            t = m_next;
            rob_q.push_back(t);
            m_busy[t]   = 1'b1;
            m_ready[t]  = 1'b0;
            m_pc[t]     = dec_pc_in;
            m_rd[t]     = dec_rd_in;
            m_has_rd[t] = dec_has_rd_in;
            m_st[t]     = dec_is_store_in;
            m_br[t]     = dec_is_branch_in;
            m_pred[t]   = dec_pred_taken_in;
            m_next      = (m_next == CAP) ? 1 : m_next + 1;
        end
    endtask

    task automatic check_query(input string name, input logic [3:0] q, input logic rdy, input logic [31:0] val);
        logic        e_rdy;
        logic [31:0] e_val;
        e_rdy = 1'b0;
        e_val = 32'd0;
        if (q != 4'd0 && m_busy[q]) begin
            e_rdy = m_ready[q];
            e_val = m_val[q];
`ifdef ROB_CDB_BYPASS_EN
            if (cdb_valid_in && cdb_tag_in == q) begin
                e_rdy = 1'b1;
                e_val = cdb_value_in;
            end
`endif
        end
        check({name, "_ready"}, rdy, e_rdy);
        if (e_rdy) check({name, "_value"}, val, e_val);
    endtask

    task automatic check_comb();
        check("next_tag", next_tag_out, 32'(m_next));
        check("rob_full", rob_full_out, (rob_q.size() == CAP) ? 32'd1 : 32'd0);
        check_query("Qj", dec_Qj_in, Qj_ready_out, Qj_value_out);
        check_query("Qk", dec_Qk_in, Qk_ready_out, Qk_value_out);
    endtask

    // Monitor: compare each registered commit slot against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("commit_signal", rob_commit_signal_out, 32'd1);
            check("commit_pc", rob_commit_pc_out, e.pc);
            check("commit_tag", rob_commit_tag_out, 32'(e.tag));
            check("commit_data", rob_commit_data_out, e.data);
            check("commit_target", rob_commit_target_out, 32'(e.rd));
            check("commit_rf", rob_commit_rf_signal_out, 32'(e.rf));
            check("commit_store", rob_commit_store_out, 32'(e.st));
            check("rollback", rob_rollback_out, 32'(e.rb));
            check("rollback_pc", rob_rollback_pc_out, e.rbpc);
        end else begin
            check("idle_flags", {rob_commit_signal_out, rob_commit_rf_signal_out,
                                 rob_commit_store_out, rob_rollback_out}, 32'd0);
            check("idle_data", rob_commit_pc_out | rob_commit_data_out | rob_rollback_pc_out |
                               32'(rob_commit_tag_out) | 32'(rob_commit_target_out), 32'd0);
        end
    end

    task automatic idle();
        dec_issue_in = 1'b0; dec_pc_in = 32'd0; dec_rd_in = 5'd0; dec_has_rd_in = 1'b0;
        dec_is_store_in = 1'b0; dec_is_branch_in = 1'b0; dec_pred_taken_in = 1'b0;
        dec_Qj_in = 4'd0; dec_Qk_in = 4'd0;
        cdb_valid_in = 1'b0; cdb_tag_in = 4'd0; cdb_value_in = 32'd0;
        cdb_taken_in = 1'b0; cdb_target_in = 32'd0;
    endtask

    task automatic set_issue(input logic [31:0] pc, input logic [4:0] rd, input logic has_rd,
                             input logic st, input logic br, input logic pred);
        dec_issue_in = 1'b1; dec_pc_in = pc; dec_rd_in = rd; dec_has_rd_in = has_rd;
        dec_is_store_in = st; dec_is_branch_in = br; dec_pred_taken_in = pred;
    endtask

    task automatic set_cdb(input logic [3:0] tag, input logic [31:0] val, input logic tk, input logic [31:0] tgt);
        cdb_valid_in = 1'b1; cdb_tag_in = tag; cdb_value_in = val;
        cdb_taken_in = tk; cdb_target_in = tgt;
    endtask

    // One cycle: check combinational outputs, advance the model at the edge.
    task automatic step();
        #1;
        check_comb();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        model_reset();
        exp_q.delete();
        check("reset_next_tag", next_tag_out, 32'd1);
        check("reset_full", rob_full_out, 32'd0);
        check("reset_commit", {rob_commit_signal_out, rob_rollback_out}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        @(negedge clk);
        do_reset();

        // Three issues receive tags 1..3.
        for (int i = 0; i < 3; i++) begin
            idle(); set_issue(32'h100 + 32'(4 * i), 5'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0); step();
        end
        idle(); #1 check("three_next_tag", next_tag_out, 32'd4);
        step();

        // Fill to capacity, then a 16th issue is ignored.
        for (int i = 3; i < CAP; i++) begin
            idle(); set_issue(32'h100 + 32'(4 * i), 5'(i + 1), 1'b1, i[0], 1'b0, 1'b0); step();
        end
        idle(); set_issue(32'hDEAD, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0); step();
        idle(); #1;
        check("full_flag", rob_full_out, 32'd1);
        check("full_next_tag", next_tag_out, 32'd1);

        // Out-of-order completion; simultaneous commit and issue while full.
        idle(); set_cdb(4'd2, 32'h55, 1'b0, 32'd0); step();
        idle(); set_cdb(4'd1, 32'h11, 1'b0, 32'd0); step();
        idle(); set_issue(32'h200, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0); step();
        idle(); #1;
        check("simul_full", rob_full_out, 32'd1);
        check("simul_next_tag", next_tag_out, 32'd2);
        for (int t = 3; t <= CAP; t++) begin
            idle(); set_cdb(4'(t), 32'(t * 16), 1'b0, 32'd0); step();
        end
        idle(); set_cdb(4'd1, 32'h77, 1'b0, 32'd0); step();
        repeat (4) begin idle(); step(); end

        // Mispredicted branch at head flushes everything.
        idle(); set_issue(32'h300, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); step();
        idle(); set_issue(32'h304, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0); step();
        idle(); set_cdb(4'(rob_q[0]), 32'd0, 1'b1, 32'h1000); step();
        idle(); step();
        idle(); #1 check("rollback_next_tag", next_tag_out, 32'd1);
        step();

        // Same-cycle query of a broadcast tag.
        for (int i = 0; i < 3; i++) begin
            idle(); set_issue(32'h400 + 32'(4 * i), 5'(i + 4), 1'b1, 1'b0, 1'b0, 1'b0); step();
        end
        idle(); dec_Qj_in = 4'd3; set_cdb(4'd3, 32'hAB, 1'b0, 32'd0); #1;
`ifdef ROB_CDB_BYPASS_EN
        check("bypass_ready", Qj_ready_out, 32'd1);
        check("bypass_value", Qj_value_out, 32'hAB);
`else
        check("nobypass_ready", Qj_ready_out, 32'd0);
`endif
        step();
        idle(); dec_Qj_in = 4'd3; #1;
        check("query_next_ready", Qj_ready_out, 32'd1);
        check("query_next_value", Qj_value_out, 32'hAB);
        step();
        idle(); set_cdb(4'd1, 32'h1, 1'b0, 32'd0); step();
        idle(); set_cdb(4'd2, 32'h2, 1'b0, 32'd0); step();
        repeat (4) begin idle(); step(); end

        // Reset with entries in flight; next issue gets tag 1.
        for (int i = 0; i < 4; i++) begin
            idle(); set_issue(32'h500 + 32'(4 * i), 5'd1, 1'b1, 1'b0, 1'b0, 1'b0); step();
        end
        idle(); do_reset();
        idle(); #1 check("post_reset_next_tag", next_tag_out, 32'd1);
        step();

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            idle();
            if ($urandom_range(0, 9) < 6)
                set_issue($urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom),
                          ($urandom_range(0, 3) == 0), 1'($urandom));
            if ($urandom_range(0, 9) < 6) begin
                if (rob_q.size() > 0 && $urandom_range(0, 7) != 0)
                    set_cdb(4'(rob_q[$urandom_range(0, rob_q.size() - 1)]), $urandom,
                            ($urandom_range(0, 3) == 0), $urandom);
                else
                    set_cdb(4'($urandom_range(0, 15)), $urandom, 1'($urandom), $urandom);
            end
            dec_Qj_in = 4'($urandom_range(0, 15));
            dec_Qk_in = (rob_q.size() > 0) ? 4'(rob_q[$urandom_range(0, rob_q.size() - 1)]) : 4'd0;
            step();
        end
        repeat (3) begin idle(); step(); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
